// File: rtl/sqrt_cordic_pkg.sv
// ----------------------------------------------------------------------------
// sqrt_cordic_pkg : shared constants and state encoding for the CORDIC sqrt path
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sqrt_cordic_pkg;

  localparam int W       = 22;
  localparam int OUT_W   = 32;
  localparam int SHIFT_W = 4;
  localparam int FRAC    = 20;

  localparam logic [SHIFT_W-1:0] K_MAX    = SHIFT_W'(10);
  localparam logic [W-1:0]       INV_GAIN = 22'h1351E8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sqrt_post_scale_if.sv
// ----------------------------------------------------------------------------
// sqrt_post_scale_if : operand/result handshake bundle of the sqrt output stage
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sqrt_post_scale_if;
  import sqrt_cordic_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       x_in;
  logic [SHIFT_W-1:0] k_in;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   sqrt_out;
  logic               err;

  modport slave (
    input  in_valid, x_in, k_in, out_ready,
    output in_ready, out_valid, sqrt_out, err
  );

  modport master (
    output in_valid, x_in, k_in, out_ready,
    input  in_ready, out_valid, sqrt_out, err
  );

endinterface

`default_nettype wire

// File: rtl/seq_shift_add_mul.sv
// ----------------------------------------------------------------------------
// seq_shift_add_mul : W x W unsigned serial multiplier, one b bit per cycle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_shift_add_mul
  import sqrt_cordic_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam logic [4:0] c_last = 5'(W - 1);

  logic [2*W-1:0] r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_acc;
  logic [4:0]     r_cnt;
  logic           r_busy;
  logic           r_done;

  // a is pre-shifted each cycle so only an adder is needed, not a barrel shifter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_a    <= {{W{1'b0}}, a};
        r_b    <= b;
        r_acc  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_b[0]) begin
          r_acc <= r_acc + r_a;
        end
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == c_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_acc;

endmodule

`default_nettype wire

// File: rtl/sqrt_post_scale.sv
// ----------------------------------------------------------------------------
// sqrt_post_scale : removes CORDIC gain and input normalisation from K*sqrt(a)
// Optional rounding: SQRT_POST_ROUND_EN.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sqrt_post_scale
  import sqrt_cordic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  sqrt_post_scale_if.slave bus
);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [W-1:0]       w_operand;
  logic [W-1:0]       w_p;
  logic [2*W-1:0]     w_prod;
  logic [SHIFT_W-1:0] r_k;
  logic               r_err;
  logic [OUT_W-1:0]   r_sqrt;

  // a negative X cannot come from a legal sqrt operand, so it is treated as zero
  assign w_operand = bus.x_in[W-1] ? '0 : bus.x_in;

  seq_shift_add_mul u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_start),
    .a       (w_operand),
    .b       (INV_GAIN),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_prod)
  );

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid && !w_mul_busy) begin
          w_start      = 1'b1;
          w_state_next = MUL;
        end
      end
      MUL:     if (w_mul_done) w_state_next = NORM;
      NORM:    w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

`ifdef SQRT_POST_ROUND_EN
  assign w_p = w_prod[FRAC+W-1:FRAC] + {{(W-1){1'b0}}, w_prod[FRAC-1]};
`else
  assign w_p = w_prod[FRAC+W-1:FRAC];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_k    <= '0;
      r_err  <= 1'b0;
      r_sqrt <= '0;
    end else begin
      if (w_start) begin
        r_k   <= (bus.k_in > K_MAX) ? K_MAX : bus.k_in;
        r_err <= bus.x_in[W-1] | (bus.k_in > K_MAX);
      end
      if (r_state == NORM) begin
        r_sqrt <= {{(OUT_W-W){1'b0}}, w_p} << r_k;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.sqrt_out  = r_sqrt;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_post_scale.sv
// ----------------------------------------------------------------------------
// tb_sqrt_post_scale : directed and random checks of sqrt_post_scale
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sqrt_post_scale;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  sqrt_post_scale_if bus ();

  sqrt_post_scale dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_sqrt(input logic [21:0] x, input logic [3:0] k);
    longint prod;
    longint p;
    int     sh;
    if (x[21]) return 32'd0;
    prod = longint'(x) * 64'd1266152;
    p    = prod >>> 20;
`ifdef SQRT_POST_ROUND_EN
    p    = p + ((prod >>> 19) & 64'd1);
`endif
    sh   = (k > 4'd10) ? 10 : int'(k);
    return 32'(p << sh);
  endfunction

  function automatic logic model_err(input logic [21:0] x, input logic [3:0] k);
    return x[21] || (k > 4'd10);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                            input int tol);
    int diff;
    diff = (obs > exp) ? int'(obs - exp) : int'(exp - obs);
    tests++;
    assert (diff <= tol) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h+-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one full transaction; bp holds out_ready low for 10 cycles in DONE
  task automatic run_op(input string tag, input logic [21:0] x, input logic [3:0] k,
                        input bit bp, output logic [31:0] got);
    int          n;
    logic [31:0] ev;
    logic        ee;
    ev = model_sqrt(x, k);
    ee = model_err(x, k);
    n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    check({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
    bus.out_ready = !bp;
    bus.in_valid  = 1'b1;
    bus.x_in      = x;
    bus.k_in      = k;
    tick();
    bus.in_valid  = 1'b0;
    bus.x_in      = 22'($urandom);
    bus.k_in      = 4'($urandom);
    n = 0;
    while (!bus.out_valid && n < 40) begin tick(); n++; end
    check({tag, "_lat"}, 64'(n), 64'd24);
    check({tag, "_sqrt"}, 64'(bus.sqrt_out), 64'(ev));
    check({tag, "_err"}, 64'(bus.err), 64'(ee));
    got = bus.sqrt_out;
    if (bp) begin
      bus.in_valid = 1'b1;
      bus.x_in     = 22'h0D4024;
      bus.k_in     = 4'd0;
      for (int i = 0; i < 10; i++) begin
        tick();
        check({tag, "_bp_hold"},
              {bus.out_valid, bus.in_ready, bus.err, bus.sqrt_out},
              {1'b1, 1'b0, ee, ev});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    tick();
    check({tag, "_back_idle"}, {bus.in_ready, bus.out_valid}, {1'b1, 1'b0});
  endtask

  initial begin
    logic [31:0] got;
    int          seen;
    tests         = 0;
    fails         = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.k_in      = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("reset_state", {bus.in_ready, bus.out_valid, bus.err, bus.sqrt_out},
          {1'b1, 1'b0, 1'b0, 32'd0});
    reset = 1'b1;
    tick();

    run_op("gain", 22'h0D4024, 4'd0, 1'b0, got);
    check_near("gain_approx", got, 32'h00100000, 2);
    run_op("denorm3", 22'h0D4024, 4'd3, 1'b0, got);
    check_near("denorm3_approx", got, 32'h00800000, 16);
    run_op("clamp12", 22'h0D4024, 4'd12, 1'b0, got);
    check_near("clamp12_approx", got, 32'h40000000, 2048);
    run_op("zero", 22'h000000, 4'd5, 1'b0, got);
    run_op("neg", 22'h200000, 4'd2, 1'b0, got);
    run_op("lsb", 22'h000001, 4'd0, 1'b0, got);
    run_op("kmax", 22'h1FFFFF, 4'd10, 1'b0, got);
    run_op("bp", 22'h0D4024, 4'd1, 1'b1, got);

    // abort in the middle of the multiply
    bus.in_valid = 1'b1;
    bus.x_in     = 22'h0D4024;
    bus.k_in     = 4'd2;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_state", {bus.in_ready, bus.out_valid, bus.sqrt_out},
          {1'b1, 1'b0, 32'd0});
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    run_op("after_abort", 22'h0D4024, 4'd0, 1'b0, got);

    for (int i = 0; i < 8; i++) begin
      run_op("rand", 22'($urandom_range(0, 22'h3FFFFF)), 4'($urandom_range(0, 15)),
             1'b0, got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
